// File: rtl/dc_bsp_pkg.sv
// dc_bsp_pkg: shared limits and arbiter state encoding for the BSP host write path
package dc_bsp_pkg;
    localparam int NUM_SRC_MIN = 2;
    localparam int NUM_SRC_MAX = 4;
    typedef enum logic {IDLE, BURST} arb_state_e;
endpackage

// File: rtl/bsp_rr_arb.sv
// bsp_rr_arb: one-hot round-robin grant, first requester at or after ptr wins
module bsp_rr_arb #(
    parameter int N = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    always_comb begin
        int best;
        int d;
        best = N;
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            d = (i >= int'(ptr)) ? i - int'(ptr) : i + N - int'(ptr);
            if (req[i] && d < best) begin
                best = d;
                gnt = '0;
                gnt[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bsp_host_mem_wr_arb.sv
// bsp_host_mem_wr_arb: burst-locked round-robin mux of N write sources onto one host write channel
module bsp_host_mem_wr_arb
    import dc_bsp_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SRC-1:0]                src_wr_write,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]     src_wr_address,
    input  logic [NUM_SRC*BURST_WIDTH-1:0]    src_wr_burstcount,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_wr_writedata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]   src_wr_byteenable,
    input  logic [NUM_SRC-1:0]                src_wr_fence,
    output logic [NUM_SRC-1:0]                src_wr_waitrequest,
    output logic                              host_wr_write,
    output logic [ADDR_WIDTH-1:0]             host_wr_address,
    output logic [BURST_WIDTH-1:0]            host_wr_burstcount,
    output logic [DATA_WIDTH-1:0]             host_wr_writedata,
    output logic [DATA_WIDTH/8-1:0]           host_wr_byteenable,
    output logic                              host_wr_fence,
    input  logic                              host_wr_waitrequest,
    output logic                              busy
);
    localparam int PW  = $clog2(NUM_SRC);
    localparam int BEW = DATA_WIDTH / 8;

    if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
        $error("NUM_SRC out of range");
    end

    arb_state_e             state, state_n;
    logic [BURST_WIDTH-1:0] cnt, cnt_n, bc;
    logic [PW-1:0]          ptr, ptr_n, lock, lock_n, gidx, sel, nxt;
    logic [NUM_SRC-1:0]     gnt;
    logic                   active, acc;

    bsp_rr_arb #(.N(NUM_SRC)) u_rr (.req(src_wr_write), .ptr(ptr), .gnt(gnt));

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_SRC; i++) if (gnt[i]) gidx = PW'(i);
    end

    assign sel    = (state == BURST) ? lock : gidx;
    assign nxt    = (sel == PW'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
    assign active = !reset && (state == BURST || |src_wr_write);
    assign busy   = (state == BURST);

    assign host_wr_write      = active && src_wr_write[sel];
    assign host_wr_fence      = host_wr_write && state == IDLE && src_wr_fence[sel];
    assign host_wr_address    = src_wr_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign host_wr_burstcount = src_wr_burstcount[int'(sel)*BURST_WIDTH +: BURST_WIDTH];
    assign host_wr_writedata  = src_wr_writedata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign host_wr_byteenable = src_wr_byteenable[int'(sel)*BEW +: BEW];
    assign bc                 = host_wr_burstcount;
    assign acc                = host_wr_write && !host_wr_waitrequest;

    // the locked source keeps seeing host backpressure even while it idles mid-burst
    always_comb begin
        src_wr_waitrequest = '1;
        for (int i = 0; i < NUM_SRC; i++)
            src_wr_waitrequest[i] = !(active && sel == PW'(i)) || host_wr_waitrequest;
    end

    // burstcount 0 and 1 both fall through the bc > 1 test as single beats
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        lock_n  = lock;
        if (acc && state == IDLE) begin
            if (bc > BURST_WIDTH'(1)) begin
                state_n = BURST;
                cnt_n   = bc - 1'b1;
                lock_n  = sel;
            end else
                ptr_n = nxt;
        end else if (acc) begin
            cnt_n = cnt - 1'b1;
            if (cnt == BURST_WIDTH'(1)) begin
                state_n = IDLE;
                ptr_n   = nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            lock  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            lock  <= lock_n;
        end
    end
endmodule
